// File: rtl/rgb_stream_packer.sv
// Packs 24-bit B,G,R pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words).
// Pads words when a line ends mid-group, and can realign the packing phase on frame start.
module rgb_stream_packer #(
    parameter logic [7:0] PAD_BYTE   = 8'h00,
    parameter bit         SOF_RESYNC = 1'b1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid,
    input  logic        sof,
    input  logic        eol,
    output logic        in_stream_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    output logic        resync
);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e      state_q;
    logic [1:0]  phase_q;
    logic [23:0] buf_q;
    logic [31:0] flush_q;
    logic        sof_pend_q;

    logic        out_free;
    logic        accept;
    logic        do_resync;
    logic [1:0]  eff_phase;
    logic        word_ld;
    logic [31:0] word_d;
    logic        word_last;
    logic        word_user;
    logic [23:0] buf_d;
    logic [1:0]  phase_d;
    logic        go_flush;
    logic [31:0] flush_d;

    assign out_stream_tkeep = 4'hF;

    always_comb begin
        out_free        = !out_stream_tvalid || out_stream_tready;
        in_stream_ready = !areset && (state_q == StRun) && out_free;
        accept          = valid && in_stream_ready;
        do_resync       = SOF_RESYNC && sof && (phase_q != 2'd0);
        eff_phase       = do_resync ? 2'd0 : phase_q;
        word_ld         = 1'b0;
        word_d          = 32'h0;
        word_last       = 1'b0;
        word_user       = sof_pend_q || sof;
        buf_d           = buf_q;
        phase_d         = phase_q;
        go_flush        = 1'b0;
        flush_d         = flush_q;
        // buf_q holds the bytes of the current group not yet placed in a word, byte 0 lowest
        unique case (eff_phase)
            2'd0: begin
                if (eol) begin
                    word_ld   = 1'b1;
                    word_d    = {PAD_BYTE, r, g, b};
                    word_last = 1'b1;
                    phase_d   = 2'd0;
                end else begin
                    buf_d   = {r, g, b};
                    phase_d = 2'd1;
                end
            end
            2'd1: begin
                word_ld = 1'b1;
                word_d  = {b, buf_q};
                buf_d   = {8'h00, r, g};
                phase_d = 2'd2;
                if (eol) begin
                    go_flush = 1'b1;
                    flush_d  = {PAD_BYTE, PAD_BYTE, r, g};
                end
            end
            2'd2: begin
                word_ld = 1'b1;
                word_d  = {g, b, buf_q[15:0]};
                buf_d   = {16'h0000, r};
                phase_d = 2'd3;
                if (eol) begin
                    go_flush = 1'b1;
                    flush_d  = {PAD_BYTE, PAD_BYTE, PAD_BYTE, r};
                end
            end
            2'd3: begin
                word_ld   = 1'b1;
                word_d    = {r, g, b, buf_q[7:0]};
                word_last = eol;
                phase_d   = 2'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q           <= StRun;
            phase_q           <= 2'd0;
            buf_q             <= 24'h0;
            flush_q           <= 32'h0;
            sof_pend_q        <= 1'b0;
            out_stream_tvalid <= 1'b0;
            out_stream_tdata  <= 32'h0;
            out_stream_tlast  <= 1'b0;
            out_stream_tuser  <= 1'b0;
            resync            <= 1'b0;
        end else begin
            resync <= accept && do_resync;
            unique case (state_q)
                StRun: begin
                    if (out_stream_tvalid && out_stream_tready) begin
                        out_stream_tvalid <= 1'b0;
                    end
                    if (accept) begin
                        phase_q <= phase_d;
                        buf_q   <= buf_d;
                        if (word_ld) begin
                            out_stream_tvalid <= 1'b1;
                            out_stream_tdata  <= word_d;
                            out_stream_tlast  <= word_last;
                            out_stream_tuser  <= word_user;
                            sof_pend_q        <= 1'b0;
                        end else begin
                            sof_pend_q <= sof_pend_q || sof;
                        end
                        if (go_flush) begin
                            flush_q <= flush_d;
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (out_free) begin
                        out_stream_tvalid <= 1'b1;
                        out_stream_tdata  <= flush_q;
                        out_stream_tlast  <= 1'b1;
                        out_stream_tuser  <= 1'b0;
                        phase_q           <= 2'd0;
                        state_q           <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Scoreboard bench for rgb_stream_packer: stimulus pushes expected words, a monitor pops them.
`timescale 1ns/1ps
module tb_rgb_stream_packer;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  r, g, b;
    logic        valid, sof, eol;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
    logic        out_stream_tready;
    logic        resync;

    int total = 0;
    int bad   = 0;
    logic [37:0] exp_q[$];
    logic [37:0] mon_e;

    always #5 aclk = ~aclk;

    rgb_stream_packer #(.PAD_BYTE(8'h00), .SOF_RESYNC(1'b1)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .valid             (valid),
        .sof               (sof),
        .eol               (eol),
        .in_stream_ready   (in_stream_ready),
        .out_stream_tdata  (out_stream_tdata),
        .out_stream_tkeep  (out_stream_tkeep),
        .out_stream_tlast  (out_stream_tlast),
        .out_stream_tuser  (out_stream_tuser),
        .out_stream_tvalid (out_stream_tvalid),
        .out_stream_tready (out_stream_tready),
        .resync            (resync)
    );

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected word layout: {tkeep, tdata, tlast, tuser}
    task automatic expect_word(input logic [31:0] d, input logic l, input logic u);
        exp_q.push_back({4'hF, d, l, u});
    endtask

    always @(negedge aclk) begin
        if (!areset && out_stream_tvalid && out_stream_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h expected none", out_stream_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("word", {out_stream_tkeep, out_stream_tdata, out_stream_tlast,
                               out_stream_tuser}, mon_e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic px(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                      input logic s, input logic e);
        int stalls;
        r = rr; g = gg; b = bb; sof = s; eol = e; valid = 1'b1;
        stalls = 0;
        @(negedge aclk);
        while (!in_stream_ready && stalls < 100) begin
            stalls++;
            @(negedge aclk);
        end
        check("no_stall", stalls, 0);
        @(posedge aclk);
        #1;
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge aclk);
        check("drain_left", exp_q.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    task automatic four_pixels();
        expect_word(32'h13010203, 1'b0, 1'b0);
        expect_word(32'h22231112, 1'b0, 1'b0);
        expect_word(32'h31323321, 1'b0, 1'b0);
        px(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        px(8'h11, 8'h12, 8'h13, 1'b0, 1'b0);
        px(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
        px(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] bq[$];
        logic       first;
        areset = 1'b1; valid = 1'b0; sof = 1'b0; eol = 1'b0;
        r = 8'h0; g = 8'h0; b = 8'h0; out_stream_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", out_stream_tvalid, 0);
        check("rst_tdata", out_stream_tdata, 0);
        check("rst_tlast_tuser", {out_stream_tlast, out_stream_tuser}, 0);
        check("rst_resync", resync, 0);
        check("rst_ready", in_stream_ready, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("ready_after_rst", in_stream_ready, 1);
        @(posedge aclk);
        #1;

        // Streaming at full rate
        four_pixels();
        drain();

        // Backpressure after word0, with P2 already offered
        expect_word(32'h13010203, 1'b0, 1'b0);
        expect_word(32'h22231112, 1'b0, 1'b0);
        expect_word(32'h31323321, 1'b0, 1'b0);
        px(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        px(8'h11, 8'h12, 8'h13, 1'b0, 1'b0);
        out_stream_tready = 1'b0;
        r = 8'h21; g = 8'h22; b = 8'h23; valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bp_hold", out_stream_tdata, 32'h13010203);
            check("bp_tvalid", out_stream_tvalid, 1);
            check("bp_ready", in_stream_ready, 0);
            @(posedge aclk);
            #1;
        end
        out_stream_tready = 1'b1;
        px(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
        px(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
        drain();

        // eol at phase 1 -> flush word, then next pixel lands at phase 0
        expect_word(32'h13010203, 1'b0, 1'b0);
        expect_word(32'h00001112, 1'b1, 1'b0);
        expect_word(32'h00212223, 1'b1, 1'b0);
        px(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        px(8'h11, 8'h12, 8'h13, 1'b0, 1'b1);
        check("flush_ready", in_stream_ready, 0);
        @(posedge aclk);
        #1;
        check("post_flush_ready", in_stream_ready, 1);
        px(8'h21, 8'h22, 8'h23, 1'b0, 1'b1);
        drain();

        // eol at phase 2
        expect_word(32'h13010203, 1'b0, 1'b0);
        expect_word(32'h22231112, 1'b0, 1'b0);
        expect_word(32'h00000021, 1'b1, 1'b0);
        px(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        px(8'h11, 8'h12, 8'h13, 1'b0, 1'b0);
        px(8'h21, 8'h22, 8'h23, 1'b0, 1'b1);
        drain();

        // sof at phase 2 discards R1/G1 and restarts packing
        expect_word(32'h13010203, 1'b0, 1'b0);
        px(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        px(8'h11, 8'h12, 8'h13, 1'b0, 1'b0);
        expect_word(32'h33212223, 1'b0, 1'b1);
        expect_word(32'h42433132, 1'b0, 1'b0);
        expect_word(32'h51525341, 1'b0, 1'b0);
        px(8'h21, 8'h22, 8'h23, 1'b1, 1'b0);
        check("resync_pulse", resync, 1);
        @(posedge aclk);
        #1;
        check("resync_one_cycle", resync, 0);
        px(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
        px(8'h41, 8'h42, 8'h43, 1'b0, 1'b0);
        px(8'h51, 8'h52, 8'h53, 1'b0, 1'b0);
        drain();

        // sof+eol at phase 1: resync then single padded word
        expect_word(32'h00717273, 1'b1, 1'b1);
        px(8'h61, 8'h62, 8'h63, 1'b0, 1'b0);
        px(8'h71, 8'h72, 8'h73, 1'b1, 1'b1);
        check("resync_sof_eol", resync, 1);
        drain();

        // Reset mid-word with phase 2 and a word pending
        out_stream_tready = 1'b0;
        px(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        px(8'h11, 8'h12, 8'h13, 1'b0, 1'b0);
        @(negedge aclk);
        check("mr_pending", {out_stream_tvalid, out_stream_tdata}, {1'b1, 32'h13010203});
        @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("mr_tvalid", out_stream_tvalid, 0);
        check("mr_tdata", out_stream_tdata, 0);
        check("mr_ready", in_stream_ready, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        out_stream_tready = 1'b1;
        four_pixels();
        drain();

        // Scaled frame: 16 x 8, sof on pixel 0, eol every 16th pixel
        first = 1'b1;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                logic [7:0] pr, pg, pb;
                pr = 8'(y * 16 + x);
                pg = 8'(x ^ 8'h5A);
                pb = 8'(x * 3 + y);
                bq.push_back(pb);
                bq.push_back(pg);
                bq.push_back(pr);
                while (bq.size() >= 4) begin
                    expect_word({bq[3], bq[2], bq[1], bq[0]},
                                (x == 15) && (bq.size() == 4), first);
                    first = 1'b0;
                    repeat (4) void'(bq.pop_front());
                end
                px(pr, pg, pb, (x == 0) && (y == 0), x == 15);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_stream_packer.md
Name: rgb_stream_packer

Overview:
- Sits directly downstream of the pixel generator.
- Accepts one 24-bit RGB pixel per handshake and packs the byte stream into 32-bit AXI4-Stream words for the VDMA: 4 pixels become 3 words.
- Carries frame-start on tuser and end-of-line on tlast.
- Handles lines that end mid-group with a zero-padded flush word, and realigns its packing phase on frame start.

Parameters:
- PAD_BYTE, 8'h00, value used to fill unused bytes of a flush word.
- SOF_RESYNC, 1, when 1 a sof pixel arriving at phase != 0 discards the stored bytes and restarts packing at phase 0.

Ports:
- aclk  in  1  stream clock.
- areset  in  1  synchronous active-high reset.
- r  in  8  red byte of the offered pixel.
- g  in  8  green byte.
- b  in  8  blue byte.
- valid  in  1  pixel offered.
- sof  in  1  offered pixel is the first of a frame.
- eol  in  1  offered pixel is the last of a line.
- in_stream_ready  out  1  pixel accepted when valid && in_stream_ready.
- out_stream_tdata  out  32  packed bytes, byte 0 in bits [7:0].
- out_stream_tkeep  out  4  constant 4'hF.
- out_stream_tlast  out  1  last word of line.
- out_stream_tuser  out  1  first word of frame.
- out_stream_tvalid  out  1  word valid.
- out_stream_tready  in  1  downstream ready.
- resync  out  1  one-cycle pulse when a sof realignment discarded bytes.

Behaviour:
- **Reset.** While areset=1, at the aclk edge:
  - tvalid, tlast, tuser, tdata, resync are set to 0.
  - phase is set to 0 and state to RUN.
  - The stored byte buffer (3 bytes) is cleared.
  - in_stream_ready is 0 while areset=1.
  - Reset takes effect mid-word and mid-flush; any pending word is dropped.
- **Byte order.** Each pixel contributes bytes in the order B, G, R. Bytes fill words LSB-first.
  - With pixels P0..P3, the three words are word0 = {B1,R0,G0,B0}, word1 = {G2,B2,R1,G1}, word2 = {R3,G3,B3,R2}.
- **Phase counter** (2 bits, 0..3) selects the pixel slot of the next accepted pixel and wraps 3 -> 0.
  - Phase 0 pixel: stores 3 bytes, emits nothing.
  - Phase 1, 2 and 3 pixels: each completes exactly one word, loaded into the output register on the accept edge. tvalid rises the next cycle.
- **Output register.** A single register holds the outgoing word.
  - It is held stable while tvalid && !tready.
  - in_stream_ready = !areset && state==RUN && (!tvalid || tready). A new word can therefore load in the same cycle the old one is taken, giving full throughput of 1 pixel/cycle.
- **tuser.** Set on the first word that contains any byte of the sof pixel.
- **tlast.** Set on the word containing the eol pixel's final byte.
- **State machine:**
  - RUN is normal operation.
  - FLUSH is entered when eol is accepted at phase 1 or 2.
    - The completed word is emitted with tlast=0.
    - The leftover bytes (G1,R1 at phase 1; R2 at phase 2) become a flush word padded with PAD_BYTE in the upper bytes, tlast=1.
    - The flush word loads when the output register frees. in_stream_ready=0 throughout FLUSH.
    - On load the state returns to RUN with phase=0.
  - eol at phase 0: a single word {PAD_BYTE,R0,G0,B0} is emitted with tlast=1 and phase returns to 0. No FLUSH.
  - eol at phase 3: normal word2 with tlast=1, phase 0. For a 640-wide line this is the only case that occurs.
- **sof at phase != 0** with SOF_RESYNC=1:
  - Stored bytes are discarded without output and resync pulses for one cycle.
  - The pixel is treated as phase 0 and stored; tuser goes on the word it later completes.
  - With SOF_RESYNC=0, sof only marks tuser and the phase is unchanged.
- **Simultaneous sof and eol** on one pixel: the resync rule applies first, then the eol-at-phase-0 rule, producing one padded word with tuser=1 and tlast=1.
- **Idle.** valid=0 causes no state change. Stored bytes are held indefinitely, with no timeout flush.
- **Latency.** From the accepting edge of a phase 1/2/3 pixel to its word being valid is 1 cycle.

Test Plan:
- **Streaming:** reset, then 4 pixels (r,g,b) = (01,02,03), (11,12,13), (21,22,23), (31,32,33) with tready=1 -> words 0x13010203, 0x22231112, 0x31323321 on consecutive cycles; in_stream_ready stays 1.
- **Full frame:** 640x480 frame with sof on pixel 0 and eol every 640th pixel -> 480 lines of 480 words each. tuser=1 only on word 0. tlast every 480th word. 230400 words total.
- **Backpressure:** as the streaming scenario but tready=0 for 5 cycles after word0 -> word0 held stable, in_stream_ready=0, no pixel lost, same three word values delivered.
- **Mid-group eol at phase 1:** eol on the second pixel (11,12,13) -> word0 0x13010203 tlast=0, then flush word 0x00001112 tlast=1, in_stream_ready=0 until the flush word is taken, next pixel stored at phase 0.
- **Resync:** sof pixel offered at phase 2 -> resync pulses for 1 cycle, no word emitted for the discarded bytes, next three pixels complete word0 with tuser=1.
- **Reset mid-operation:** assert areset with tvalid=1 and phase=2 -> next cycle tvalid=0, tdata=0, phase=0, and post-reset packing starts clean.
